// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak command path: instruction codes, the
// cmd0 field layout and the sequencer state encoding.
package keccak_pkg;

  localparam int CMD_W   = 32;
  localparam int INS_W   = 5;
  localparam int INS_LSB = 0;
  localparam int OP_W    = 9;

  typedef enum logic [INS_W-1:0] {
    INS_CLR        = 5'd0,
    INS_SHA3_256   = 5'd1,
    INS_SHA3_512   = 5'd2,
    INS_SHAKE      = 5'd3,
    INS_SHAKE_IRST = 5'd4,
    INS_SHAKE_NEXT = 5'd5,
    INS_NOP        = 5'd31
  } ins_e;

  typedef struct packed {
    logic [OP_W-1:0]  op3;
    logic [OP_W-1:0]  op2;
    logic [OP_W-1:0]  op1;
    logic [INS_W-1:0] ins;
  } cmd0_t;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_CLR,
    ST_START,
    ST_WAIT,
    ST_PARK,
    ST_RETIRE
  } seq_state_e;

  function automatic logic [INS_W-1:0] cmd0_ins(input logic [CMD_W-1:0] cmd0);
    return cmd0[INS_LSB +: INS_W];
  endfunction

endpackage

// File: rtl/cmd_pair_fifo.sv
// Synchronous queue of {cmd0,cmd1} pairs; pushes while full and pops while
// empty are ignored.
module cmd_pair_fifo
  import keccak_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2*CMD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wr_data_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/keccak_cmd_sequencer.sv
// Issues queued {cmd0,cmd1} pairs to the Keccak wrapper command registers and
// parks the wrapper on a NOP once each job reports done.
//
// state  | meaning
// INIT   | write NOP into reg0 once after reset
// IDLE   | wait for a queued pair
// LOAD0  | write head.cmd0 to reg0
// LOAD1  | write head.cmd1 to reg1
// CLR    | hold a clear for CLEAR_CYCLES, no start pulse
// START  | pulse command_enable, restart watchdog
// WAIT   | wait for a fresh done (low seen, then high) or a timeout
// PARK   | write NOP into reg0 to hand BRAM back
// RETIRE | pop the head, pulse op_done
module keccak_cmd_sequencer
  import keccak_pkg::*;
#(
  parameter int               FIFO_DEPTH   = 4,
  parameter int               CLEAR_CYCLES = 2,
  parameter int               TIMEOUT_W    = 16,
  parameter logic [INS_W-1:0] NOP_INS      = INS_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd0_in,
  input  logic [31:0] cmd1_in,
  output logic [31:0] command_in,
  output logic        command_we0,
  output logic        command_we1,
  output logic        command_enable,
  input  logic        done_shake,
  output logic        busy,
  output logic        op_done,
  output logic        err,
  input  logic        err_clr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0]     FULL_CNT = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [CLR_W-1:0]     CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [CMD_W-1:0]     NOP_WORD = {{(CMD_W-INS_W){1'b0}}, NOP_INS};

  seq_state_e           state_q, state_d;
  logic [CMD_W-1:0]     command_in_q, command_in_d;
  logic                 we0_q, we0_d, we1_q, we1_d, en_q, en_d;
  logic                 op_done_q, op_done_d, err_q, err_d;
  logic                 busy_q, busy_d, cmd_ready_q, cmd_ready_d;
  logic                 done_q, arm_q, arm_d, timeout;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [CLR_W-1:0]     clr_q, clr_d;

  logic [2*CMD_W-1:0]   fifo_rdata;
  logic [CNT_W-1:0]     fifo_count, count_nxt;
  logic                 fifo_full, fifo_empty, push_acc, pop;
  logic [CMD_W-1:0]     head_cmd0, head_cmd1;

  assign push_acc  = cmd_valid && cmd_ready_q && !fifo_full;
  assign pop       = (state_q == ST_RETIRE) && !fifo_empty;
  assign head_cmd0 = fifo_rdata[2*CMD_W-1:CMD_W];
  assign head_cmd1 = fifo_rdata[CMD_W-1:0];
  assign count_nxt = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);

  cmd_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_acc),
    .pop_i     (pop),
    .wr_data_i ({cmd0_in, cmd1_in}),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    command_in_d = command_in_q;
    we0_d        = 1'b0;
    we1_d        = 1'b0;
    en_d         = 1'b0;
    op_done_d    = 1'b0;
    arm_d        = arm_q;
    wd_d         = wd_q;
    clr_d        = clr_q;
    timeout      = 1'b0;
    case (state_q)
      ST_INIT: begin
        command_in_d = NOP_WORD;
        we0_d        = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD0;
      ST_LOAD0: begin
        command_in_d = head_cmd0;
        we0_d        = 1'b1;
        state_d      = ST_LOAD1;
      end
      ST_LOAD1: begin
        command_in_d = head_cmd1;
        we1_d        = 1'b1;
        if (cmd0_ins(head_cmd0) == INS_CLR) begin
          clr_d   = CLR_LOAD;
          state_d = ST_CLR;
        end else begin
          state_d = ST_START;
        end
      end
      // A clear must stay latched in reg0, so it retires without PARK.
      ST_CLR: begin
        if (clr_q == '0) state_d = ST_RETIRE;
        else             clr_d   = clr_q - CLR_W'(1);
      end
      ST_START: begin
        en_d    = 1'b1;
        wd_d    = '0;
        arm_d   = 1'b0;
        state_d = ST_WAIT;
      end
      // Done is only trusted after it has been seen low in this job.
      ST_WAIT: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (!done_q) arm_d = 1'b1;
        if (done_q && arm_q) begin
          state_d = ST_PARK;
        end else if (wd_q == WD_LAST) begin
          timeout = 1'b1;
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        command_in_d = NOP_WORD;
        we0_d        = 1'b1;
        state_d      = ST_RETIRE;
      end
      ST_RETIRE: begin
        op_done_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign err_d       = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  assign busy_d      = (state_d != ST_IDLE && state_d != ST_INIT) || (count_nxt != '0);
  assign cmd_ready_d = (count_nxt != FULL_CNT) && (state_d != ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      command_in_q <= '0;
      we0_q        <= 1'b0;
      we1_q        <= 1'b0;
      en_q         <= 1'b0;
      op_done_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      arm_q        <= 1'b0;
      wd_q         <= '0;
      clr_q        <= '0;
    end else begin
      state_q      <= state_d;
      command_in_q <= command_in_d;
      we0_q        <= we0_d;
      we1_q        <= we1_d;
      en_q         <= en_d;
      op_done_q    <= op_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_shake;
      arm_q        <= arm_d;
      wd_q         <= wd_d;
      clr_q        <= clr_d;
    end
  end

  assign command_in     = command_in_q;
  assign command_we0    = we0_q;
  assign command_we1    = we1_q;
  assign command_enable = en_q;
  assign op_done        = op_done_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign cmd_ready      = cmd_ready_q;

endmodule

// File: tb/tb_keccak_cmd_sequencer.sv
// Scoreboard bench: stimulus queues the expected register writes, strobes and
// spacing; a monitor pops and compares each one as the sequencer emits it.
module tb_keccak_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CLR   = 2;
  localparam int TW    = 4;
  localparam int M_NORMAL = 0, M_STALE = 1, M_NEVER = 2, M_CLEAR = 3, M_PARTIAL = 4;
  localparam int K_WE0 = 0, K_WE1 = 1, K_EN = 2, K_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd0_in = '0, cmd1_in = '0;
  logic        done_shake = 1'b0;
  logic        err_clr = 1'b0;
  logic        cmd_ready, command_we0, command_we1, command_enable;
  logic        busy, op_done, err;
  logic [31:0] command_in;

  always #5 clk = ~clk;

  keccak_cmd_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .CLEAR_CYCLES (CLR),
    .TIMEOUT_W    (TW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd0_in        (cmd0_in),
    .cmd1_in        (cmd1_in),
    .command_in     (command_in),
    .command_we0    (command_we0),
    .command_we1    (command_we1),
    .command_enable (command_enable),
    .done_shake     (done_shake),
    .busy           (busy),
    .op_done        (op_done),
    .err            (err),
    .err_clr        (err_clr)
  );

  typedef struct {int kind; logic [31:0] data; int gap;} ev_t;
  typedef struct {int drop_at; int rise_at;} mode_t;
  ev_t   exp_q[$];
  mode_t mode_q[$];
  int total = 0, bad = 0;
  int cyc = 0, last_cyc = 0, evn = 0, n_en = 0, n_op = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sb(input int kind, input logic [31:0] data);
    ev_t e;
    int  gap;
    gap      = cyc - last_cyc;
    last_cyc = cyc;
    evn++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event%0d: got kind=%0d data=%h want none", evn, kind, data);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event%0d_kind_data", evn), 64'({2'(kind), data}), 64'({2'(e.kind), e.data}));
      if (e.gap >= 0) check($sformatf("event%0d_gap", evn), 64'(gap), 64'(e.gap));
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (command_we0 || command_we1 || command_enable)
        check("strobe_onehot", 64'($countones({command_we0, command_we1, command_enable})), 64'(1));
      if (command_we0) sb(K_WE0, command_in);
      if (command_we1) sb(K_WE1, command_in);
      if (command_enable) begin n_en++; sb(K_EN, 32'h0); end
      if (op_done) begin n_op++; sb(K_DONE, 32'h0); end
    end
  end

  // Wrapper model: done level drops/rises a set number of cycles after start.
  mode_t mcur;
  int    mk = 0;
  logic  mact = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 1'b0;
    end else begin
      if (command_enable) begin
        if (mode_q.size() > 0) mcur = mode_q.pop_front();
        else mcur = '{0, 10};
        mk   = 0;
        mact = 1'b1;
      end else if (mact) begin
        mk++;
      end
      if (mact) begin
        if (mk == mcur.drop_at) done_shake = 1'b0;
        if (mk == mcur.rise_at) begin done_shake = 1'b1; mact = 1'b0; end
      end
    end
  end

  task automatic expect_job(input logic [31:0] c0, input logic [31:0] c1, input int first_gap, input int mode);
    int park_gap;
    exp_q.push_back('{K_WE0, c0, first_gap});
    exp_q.push_back('{K_WE1, c1, 1});
    if (mode == M_CLEAR) begin
      exp_q.push_back('{K_DONE, 32'h0, CLR + 1});
      return;
    end
    exp_q.push_back('{K_EN, 32'h0, 1});
    case (mode)
      M_STALE: begin mode_q.push_back('{3, 5});  park_gap = 8;       end
      M_NEVER: begin mode_q.push_back('{0, -1}); park_gap = 1 << TW; end
      default: begin mode_q.push_back('{0, 10}); park_gap = 13;      end
    endcase
    if (mode == M_PARTIAL) return;
    exp_q.push_back('{K_WE0, 32'h0000_001F, park_gap});
    exp_q.push_back('{K_DONE, 32'h0, 1});
  endtask

  task automatic push(input logic [31:0] c0, input logic [31:0] c1);
    int n = 0;
    cmd0_in   = c0;
    cmd1_in   = c1;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got cmd_ready=0 want 1");
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    check({name, "_idle"}, 64'({busy, exp_q.size() == 0}), 64'(2'b01));
  endtask

  initial begin
    int base;
    logic [31:0] c0s[5], c1s[5];

    // 1: reset values, INIT NOP write, then idle
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({command_in, command_we0, command_we1, command_enable,
                                busy, op_done, err, cmd_ready}), 64'(0));
    exp_q.push_back('{K_WE0, 32'h0000_001F, -1});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_busy_ready", 64'({busy, cmd_ready}), 64'(2'b01));
    wait_idle("t1");

    // 2: single SHA3-256 job
    base = n_op;
    expect_job(32'h0000_0001, 32'h0020_0040, -1, M_NORMAL);
    push(32'h0000_0001, 32'h0020_0040);
    wait_idle("t2");
    check("t2_op_done_count", 64'(n_op - base), 64'(1));

    // 3: clear then SHAKE; only the SHAKE starts
    base = n_en;
    expect_job(32'h0000_0000, 32'h0003_0004, -1, M_CLEAR);
    expect_job(32'h0000_0063, 32'h0088_0044, 2, M_NORMAL);
    push(32'h0000_0000, 32'h0003_0004);
    push(32'h0000_0063, 32'h0088_0044);
    wait_idle("t3");
    check("t3_enable_count", 64'(n_en - base), 64'(1));

    // 4: stale done held high across START
    expect_job(32'h0000_0022, 32'h0010_0020, -1, M_STALE);
    push(32'h0000_0022, 32'h0010_0020);
    wait_idle("t4");

    // 5: watchdog timeout, next job still runs, err sticky until cleared
    check("t5_err_before", 64'(err), 64'(0));
    base = n_op;
    expect_job(32'h0000_0024, 32'h0004_0008, -1, M_NEVER);
    expect_job(32'h0000_0045, 32'h0005_0009, 2, M_NORMAL);
    push(32'h0000_0024, 32'h0004_0008);
    push(32'h0000_0045, 32'h0005_0009);
    for (int i = 0; i < 200 && n_op == base; i++) @(negedge clk);
    check("t5_err_set", 64'(err), 64'(1));
    wait_idle("t5");
    check("t5_err_sticky", 64'(err), 64'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_cleared", 64'(err), 64'(0));

    // 6: five pairs into a depth-4 queue
    for (int i = 0; i < 5; i++) begin
      c0s[i] = 32'h0000_0001 | (32'(i + 1) << 5);
      c1s[i] = (32'(i + 1) << 16) | 32'h0000_0008;
      expect_job(c0s[i], c1s[i], (i == 0) ? -1 : 2, M_NORMAL);
    end
    base = n_op;
    for (int i = 0; i < 4; i++) push(c0s[i], c1s[i]);
    check("t6_ready_when_full", 64'(cmd_ready), 64'(0));
    push(c0s[4], c1s[4]);
    check("t6_fifth_after_first_pop", 64'(n_op - base), 64'(1));
    wait_idle("t6");
    check("t6_retired", 64'(n_op - base), 64'(5));

    // 6b: async reset mid-WAIT drops the queue and re-runs INIT
    base = n_en;
    expect_job(32'h0000_0041, 32'h0011_0022, -1, M_PARTIAL);
    push(32'h0000_0041, 32'h0011_0022);
    push(32'h0000_0061, 32'h0033_0044);
    push(32'h0000_0081, 32'h0055_0066);
    for (int i = 0; i < 100 && n_en == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6b_async_reset", 64'({command_we0, command_we1, command_enable,
                                  busy, op_done, cmd_ready}), 64'(0));
    check("t6b_pending_before_reset", 64'(exp_q.size()), 64'(0));
    mode_q.delete();
    exp_q.push_back('{K_WE0, 32'h0000_001F, -1});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6b_post_reset_idle", 64'({busy, cmd_ready}), 64'(2'b01));
    repeat (30) @(negedge clk);
    check("t6b_queue_dropped", 64'({busy, exp_q.size() == 0}), 64'(2'b01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
